// File: rtl/error_status_decoder.sv
// Error-code receiver: decodes the 2-bit result code into sticky flags, an interrupt FSM and saturating counters.
// Optional 4-entry history FIFO of nonzero codes is included when ERR_HISTORY_EN is defined.
module error_status_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             code_valid,
  input  logic [1:0]       error_code,
  input  logic             ack,
  input  logic             clr_cnt,
`ifdef ERR_HISTORY_EN
  input  logic             hist_pop,
  output logic [1:0]       hist_code,
  output logic             hist_empty,
`endif
  output logic             ovf_flag,
  output logic             dbz_flag,
  output logic             err_irq,
  output logic [CNT_W-1:0] ovf_count,
  output logic [CNT_W-1:0] dbz_count,
  output logic [1:0]       last_code,
  output logic [1:0]       state_out
);

  typedef enum logic [1:0] {
    S_OK   = 2'b00,
    S_PEND = 2'b01,
    S_CLR  = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic             r_ovf_flag;
  logic             r_dbz_flag;
  logic             r_err_irq;
  logic [CNT_W-1:0] r_ovf_count;
  logic [CNT_W-1:0] r_dbz_count;
  logic [1:0]       r_last_code;

  logic w_ovf_ev;
  logic w_dbz_ev;
  logic w_err;

  assign w_ovf_ev = code_valid & error_code[1];
  assign w_dbz_ev = code_valid & error_code[0];
  assign w_err    = w_ovf_ev | w_dbz_ev;

  // A clear that coincides with an event leaves the counter at 1 so the event is kept.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic ev, input logic clr);
    if (clr)
      return CNT_W'(ev);
    if (ev && (c != CNT_MAX))
      return c + 1'b1;
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_OK;
      r_ovf_flag  <= 1'b0;
      r_dbz_flag  <= 1'b0;
      r_err_irq   <= 1'b0;
      r_ovf_count <= '0;
      r_dbz_count <= '0;
      r_last_code <= 2'b00;
    end else begin
      if (code_valid)
        r_last_code <= error_code;
      r_ovf_count <= sat_inc(r_ovf_count, w_ovf_ev, clr_cnt);
      r_dbz_count <= sat_inc(r_dbz_count, w_dbz_ev, clr_cnt);

      case (r_state)
        S_PEND: begin
          if (ack && !w_err) begin
            r_ovf_flag <= 1'b0;
            r_dbz_flag <= 1'b0;
            r_err_irq  <= 1'b0;
            r_state    <= S_CLR;
          end else if (ack) begin
            // Acknowledge with a fresh error: flags restart from the new code alone.
            r_ovf_flag <= w_ovf_ev;
            r_dbz_flag <= w_dbz_ev;
          end else begin
            r_ovf_flag <= r_ovf_flag | w_ovf_ev;
            r_dbz_flag <= r_dbz_flag | w_dbz_ev;
          end
        end
        default: begin
          if (w_err) begin
            r_ovf_flag <= w_ovf_ev;
            r_dbz_flag <= w_dbz_ev;
            r_err_irq  <= 1'b1;
            r_state    <= S_PEND;
          end else begin
            r_ovf_flag <= 1'b0;
            r_dbz_flag <= 1'b0;
            r_err_irq  <= 1'b0;
            r_state    <= S_OK;
          end
        end
      endcase
    end
  end

  assign ovf_flag  = r_ovf_flag;
  assign dbz_flag  = r_dbz_flag;
  assign err_irq   = r_err_irq;
  assign ovf_count = r_ovf_count;
  assign dbz_count = r_dbz_count;
  assign last_code = r_last_code;
  assign state_out = r_state;

`ifdef ERR_HISTORY_EN
  logic [1:0] r_hist_mem [4];
  logic [1:0] r_hist_rd;
  logic [2:0] r_hist_cnt;
  logic       w_hist_pop;
  logic       w_hist_full;
  logic [1:0] w_hist_wr;

  assign w_hist_pop  = hist_pop && (r_hist_cnt != 3'd0);
  assign w_hist_full = r_hist_cnt[2];
  // When full the write slot equals the read slot, so the oldest entry is overwritten.
  assign w_hist_wr   = r_hist_rd + r_hist_cnt[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist_rd  <= 2'd0;
      r_hist_cnt <= 3'd0;
    end else begin
      if (w_hist_pop || (w_err && w_hist_full))
        r_hist_rd <= r_hist_rd + 2'd1;
      if (w_err && !w_hist_pop && !w_hist_full)
        r_hist_cnt <= r_hist_cnt + 3'd1;
      else if (w_hist_pop && !w_err)
        r_hist_cnt <= r_hist_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_err)
      r_hist_mem[w_hist_wr] <= error_code;
  end

  assign hist_empty = (r_hist_cnt == 3'd0);
  assign hist_code  = hist_empty ? 2'b00 : r_hist_mem[r_hist_rd];
`endif

endmodule

// File: tb/tb_error_status_decoder.sv
// Scoreboard bench for error_status_decoder: a CNT_W=8 and a CNT_W=2 instance share the same stimulus.
// History-FIFO expectations are compared only when ERR_HISTORY_EN is defined.
module tb_error_status_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       code_valid = 1'b0;
  logic [1:0] error_code = 2'b00;
  logic       ack = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       hist_pop = 1'b0;

  logic       ovf_flag, dbz_flag, err_irq;
  logic [7:0] ovf_count, dbz_count;
  logic [1:0] last_code, state_out;
  logic       ovf_flag2, dbz_flag2, err_irq2;
  logic [1:0] ovf_count2, dbz_count2, last_code2, state_out2;
  logic [1:0] hist_code;
  logic       hist_empty;
  logic [1:0] hist_code2;
  logic       hist_empty2;

  int cycle  = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    string      name;
    logic [2:0] fl;
    logic [7:0] oc;
    logic [7:0] dc;
    logic [1:0] oc2;
    logic [1:0] dc2;
    logic [1:0] last;
    logic [1:0] st;
    logic [1:0] hc;
    logic       he;
  } exp_t;

  exp_t sb[$];

  error_status_decoder #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .code_valid(code_valid), .error_code(error_code),
    .ack(ack), .clr_cnt(clr_cnt),
`ifdef ERR_HISTORY_EN
    .hist_pop(hist_pop), .hist_code(hist_code), .hist_empty(hist_empty),
`endif
    .ovf_flag(ovf_flag), .dbz_flag(dbz_flag), .err_irq(err_irq),
    .ovf_count(ovf_count), .dbz_count(dbz_count),
    .last_code(last_code), .state_out(state_out)
  );

  error_status_decoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .code_valid(code_valid), .error_code(error_code),
    .ack(ack), .clr_cnt(clr_cnt),
`ifdef ERR_HISTORY_EN
    .hist_pop(hist_pop), .hist_code(hist_code2), .hist_empty(hist_empty2),
`endif
    .ovf_flag(ovf_flag2), .dbz_flag(dbz_flag2), .err_irq(err_irq2),
    .ovf_count(ovf_count2), .dbz_count(dbz_count2),
    .last_code(last_code2), .state_out(state_out2)
  );

`ifndef ERR_HISTORY_EN
  assign hist_code   = 2'b00;
  assign hist_empty  = 1'b1;
  assign hist_code2  = 2'b00;
  assign hist_empty2 = 1'b1;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: every expected record becomes due one edge after its stimulus.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cycle) begin
      exp_t e;
      logic [39:0] act, req;
      e = sb.pop_front();
      act = {8'h00, ovf_flag, dbz_flag, err_irq, ovf_count, dbz_count,
             ovf_count2, dbz_count2, last_code, state_out, 5'd0};
      req = {8'h00, e.fl, e.oc, e.dc, e.oc2, e.dc2, e.last, e.st, 5'd0};
`ifdef ERR_HISTORY_EN
      act[39:32] = {hist_code, hist_empty, hist_code2, hist_empty2, 2'b00};
      req[39:32] = {e.hc, e.he, e.hc, e.he, 2'b00};
`endif
      checks++;
      if (act !== req || ovf_flag2 !== e.fl[2] || dbz_flag2 !== e.fl[1] ||
          err_irq2 !== e.fl[0] || last_code2 !== e.last || state_out2 !== e.st) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, cycle, act, req);
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic cv, input logic [1:0] code,
                      input logic a, input logic c, input logic p,
                      input logic [2:0] fl, input logic [7:0] oc, input logic [7:0] dc,
                      input logic [1:0] oc2, input logic [1:0] dc2, input logic [1:0] last,
                      input logic [1:0] st, input logic [1:0] hc, input logic he);
    exp_t e;
    rst = r; code_valid = cv; error_code = code; ack = a; clr_cnt = c; hist_pop = p;
    e.cyc = cycle + 1; e.name = nm; e.fl = fl; e.oc = oc; e.dc = dc; e.oc2 = oc2;
    e.dc2 = dc2; e.last = last; e.st = st; e.hc = hc; e.he = he;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    //   name        rst cv code ack clr pop  {ovf,dbz,irq} oc dc oc2 dc2 last st hc he
    step("rst_coinc",  1, 1, 2'b11, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1);
    step("rst_hold",   1, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1);
    for (int i = 0; i < 3; i++)
      step("clean00",  0, 1, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1);
    step("ovf_evt",    0, 1, 2'b10, 0, 0, 0, 3'b101, 1, 0, 1, 0, 2'b10, 2'b01, 2'b10, 0);
    step("ack_to_clr", 0, 0, 2'b00, 1, 0, 0, 3'b000, 1, 0, 1, 0, 2'b10, 2'b10, 2'b10, 0);
    step("clr_to_ok",  0, 0, 2'b00, 0, 0, 0, 3'b000, 1, 0, 1, 0, 2'b10, 2'b00, 2'b10, 0);
    step("ack_in_ok",  0, 0, 2'b00, 1, 0, 0, 3'b000, 1, 0, 1, 0, 2'b10, 2'b00, 2'b10, 0);
    step("both_evt",   0, 1, 2'b11, 0, 0, 0, 3'b111, 2, 1, 2, 1, 2'b11, 2'b01, 2'b10, 0);
    step("dbz_or",     0, 1, 2'b01, 0, 0, 0, 3'b111, 2, 2, 2, 2, 2'b01, 2'b01, 2'b10, 0);
    step("ack_newcode",0, 1, 2'b01, 1, 0, 0, 3'b011, 2, 3, 2, 3, 2'b01, 2'b01, 2'b10, 0);
    step("dbz_sat2",   0, 1, 2'b01, 0, 0, 0, 3'b011, 2, 4, 2, 3, 2'b01, 2'b01, 2'b11, 0);
    step("ack_clr2",   0, 0, 2'b00, 1, 0, 0, 3'b000, 2, 4, 2, 3, 2'b01, 2'b10, 2'b11, 0);
    step("evt_in_clr", 0, 1, 2'b10, 1, 0, 0, 3'b101, 3, 4, 3, 3, 2'b10, 2'b01, 2'b01, 0);
    step("invalid",    0, 0, 2'b11, 0, 0, 0, 3'b101, 3, 4, 3, 3, 2'b10, 2'b01, 2'b01, 0);
    step("clrcnt_evt", 0, 1, 2'b01, 0, 1, 0, 3'b111, 0, 1, 0, 1, 2'b01, 2'b01, 2'b01, 0);
    step("clrcnt",     0, 0, 2'b00, 0, 1, 0, 3'b111, 0, 0, 0, 0, 2'b01, 2'b01, 2'b01, 0);
    step("ovf_cnt1",   0, 1, 2'b10, 0, 0, 0, 3'b111, 1, 0, 1, 0, 2'b10, 2'b01, 2'b01, 0);
    step("ovf_cnt2",   0, 1, 2'b10, 0, 0, 0, 3'b111, 2, 0, 2, 0, 2'b10, 2'b01, 2'b10, 0);
    step("ovf_cnt3",   0, 1, 2'b10, 0, 0, 0, 3'b111, 3, 0, 3, 0, 2'b10, 2'b01, 2'b01, 0);
    step("ovf_sat",    0, 1, 2'b10, 0, 0, 0, 3'b111, 4, 0, 3, 0, 2'b10, 2'b01, 2'b10, 0);
    step("ack_clr3",   0, 0, 2'b00, 1, 0, 0, 3'b000, 4, 0, 3, 0, 2'b10, 2'b10, 2'b10, 0);
    step("clean_clr",  0, 1, 2'b00, 0, 0, 0, 3'b000, 4, 0, 3, 0, 2'b00, 2'b00, 2'b10, 0);
    step("pend_again", 0, 1, 2'b10, 0, 0, 0, 3'b101, 5, 0, 3, 0, 2'b10, 2'b01, 2'b10, 0);
    step("rst_mid",    1, 1, 2'b11, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1);
    step("h_push01",   0, 1, 2'b01, 0, 0, 0, 3'b011, 0, 1, 0, 1, 2'b01, 2'b01, 2'b01, 0);
    step("h_push10",   0, 1, 2'b10, 0, 0, 0, 3'b111, 1, 1, 1, 1, 2'b10, 2'b01, 2'b01, 0);
    step("h_push11",   0, 1, 2'b11, 0, 0, 0, 3'b111, 2, 2, 2, 2, 2'b11, 2'b01, 2'b01, 0);
    step("h_push01b",  0, 1, 2'b01, 0, 0, 0, 3'b111, 2, 3, 2, 3, 2'b01, 2'b01, 2'b01, 0);
    step("h_full_drop",0, 1, 2'b10, 0, 0, 0, 3'b111, 3, 3, 3, 3, 2'b10, 2'b01, 2'b10, 0);
    step("h_pop1",     0, 0, 2'b00, 0, 0, 1, 3'b111, 3, 3, 3, 3, 2'b10, 2'b01, 2'b11, 0);
    step("h_pop2",     0, 0, 2'b00, 0, 0, 1, 3'b111, 3, 3, 3, 3, 2'b10, 2'b01, 2'b01, 0);
    step("h_pop3",     0, 0, 2'b00, 0, 0, 1, 3'b111, 3, 3, 3, 3, 2'b10, 2'b01, 2'b10, 0);
    step("h_pop4",     0, 0, 2'b00, 0, 0, 1, 3'b111, 3, 3, 3, 3, 2'b10, 2'b01, 2'b00, 1);
    step("h_pop_empty",0, 0, 2'b00, 0, 0, 1, 3'b111, 3, 3, 3, 3, 2'b10, 2'b01, 2'b00, 1);
    step("h_pp_empty", 0, 1, 2'b11, 0, 0, 1, 3'b111, 4, 4, 3, 3, 2'b11, 2'b01, 2'b11, 0);
    step("h_pp_one",   0, 1, 2'b01, 0, 0, 1, 3'b111, 4, 5, 3, 3, 2'b01, 2'b01, 2'b01, 0);
    step("h_pop_last", 0, 0, 2'b00, 0, 0, 1, 3'b111, 4, 5, 3, 3, 2'b01, 2'b01, 2'b00, 1);
    code_valid = 1'b0; hist_pop = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d expected completion", cycle);
    $fatal(1, "timeout");
  end

endmodule
